usr_btn_ctrl: RTL and testbench

Button front-end for the OrangeCrab user button `usr_btn`. It synchronises and debounces the raw pin and classifies each press as short or long. A long press drives a timed active-low reboot pulse, which the top level routes to the `rst_n` pin to enter the bootloader. The block sits directly upstream of the top-level reset and LED logic and replaces the raw `usr_btn`→`rst_n` path.

---
 rtl/usr_btn_ctrl.sv | 124 ++++++++++++
 tb/tb_usr_btn_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/usr_btn_ctrl.sv
// OrangeCrab user-button front end: synchronise, debounce, classify short/long
// presses and issue a timed active-low reboot pulse on a long press.
module usr_btn_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 480000,
  parameter int unsigned LONG_CYC     = 96000000,
  parameter int unsigned REBOOT_CYC   = 4800,
  parameter int unsigned REBOOT_EN    = 1
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic usr_btn,
  output logic btn_pressed,
  output logic short_press,
  output logic long_press,
  output logic reboot_n
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int HOLD_W = $clog2(LONG_CYC);
  localparam int RB_W   = $clog2(REBOOT_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [RB_W-1:0]   RB_LAST   = RB_W'(REBOOT_CYC - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESSED   = 2'd1;
  localparam logic [1:0] LONG_HELD = 2'd2;
  localparam logic [1:0] REBOOT    = 2'd3;

  logic              sync_p0;
  logic              sync_p1;
  logic              db;
  logic [DB_W-1:0]   db_cnt;
  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RB_W-1:0]   rb_cnt;

  // Stage p0/p1: two-flop synchroniser, idles at the released level
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= usr_btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level only follows sync after DEBOUNCE_CYC consecutive disagreeing cycles
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 1'b1;
      db_cnt <= '0;
    end else if (sync_p1 != db) begin
      if (db_cnt == DB_LAST) begin
        db     <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_pressed = ~db;

  // Press classifier; release wins over the long threshold in the same cycle
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      rb_cnt      <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      reboot_n    <= 1'b1;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_pressed) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (!btn_pressed) begin
            short_press <= 1'b1;
            state       <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            long_press <= 1'b1;
            if (REBOOT_EN != 0) begin
              state    <= REBOOT;
              reboot_n <= 1'b0;
              rb_cnt   <= '0;
            end else begin
              state <= LONG_HELD;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        REBOOT: begin
          // Pulse width is fixed; the button level is ignored here
          if (rb_cnt == RB_LAST) begin
            reboot_n <= 1'b1;
            state    <= LONG_HELD;
          end else begin
            rb_cnt <= rb_cnt + RB_W'(1);
          end
        end
        LONG_HELD: begin
          if (!btn_pressed) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_btn_ctrl.sv
// Directed bench for usr_btn_ctrl with small timing parameters (4/20/3).
module tb_usr_btn_ctrl;

  localparam int NONE = 9999;

  logic clk48;
  logic rst_n;
  logic usr_btn;
  logic btn_pressed;
  logic short_press;
  logic long_press;
  logic reboot_n;

  int tests;
  int failed;

  typedef struct {
    int low;   // cycles usr_btn is held low from edge 0
    int run;   // edges observed
    int rise;  // first edge after which btn_pressed is 1 (-1: already high)
    int fall;  // first edge after which btn_pressed is 0 again
    int sp;    // edge after which short_press is high
    int lp;    // edge after which long_press is high; reboot_n low for lp..lp+2
  } vec_t;

  vec_t vecs[6];

  usr_btn_ctrl #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (20),
    .REBOOT_CYC  (3),
    .REBOOT_EN   (1)
  ) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .usr_btn    (usr_btn),
    .btn_pressed(btn_pressed),
    .short_press(short_press),
    .long_press (long_press),
    .reboot_n   (reboot_n)
  );

  initial clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  task automatic chk(input string name, input int edge_no, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_no, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e, input logic bp, input logic sp,
                           input logic lp, input logic rb);
    chk({tag, ".btn_pressed"}, e, btn_pressed, bp);
    chk({tag, ".short_press"}, e, short_press, sp);
    chk({tag, ".long_press"},  e, long_press,  lp);
    chk({tag, ".reboot_n"},    e, reboot_n,    rb);
  endtask

  task automatic run_press(input string tag, input vec_t v);
    logic bp;
    logic rb;
    for (int e = 0; e < v.run; e++) begin
      usr_btn = (e < v.low) ? 1'b0 : 1'b1;
      @(posedge clk48);
      #1;
      bp = (e >= v.rise) && (e < v.fall);
      rb = !((e >= v.lp) && (e < v.lp + 3));
      check_all(tag, e, bp, (e == v.sp), (e == v.lp), rb);
    end
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst_n   = 1'b0;
    usr_btn = 1'b1;

    vecs[0] = '{low: 10, run: 30, rise: 5,    fall: 15, sp: 16,   lp: NONE};
    vecs[1] = '{low: 60, run: 80, rise: 5,    fall: 65, sp: NONE, lp: 26};
    vecs[2] = '{low: 20, run: 40, rise: 5,    fall: 25, sp: 26,   lp: NONE};
    vecs[3] = '{low: 21, run: 40, rise: 5,    fall: 26, sp: NONE, lp: 26};
    vecs[4] = '{low: 4,  run: 20, rise: 5,    fall: 9,  sp: 10,   lp: NONE};
    vecs[5] = '{low: 3,  run: 20, rise: NONE, fall: 0,  sp: NONE, lp: NONE};

    // Reset values, during reset and for 100 idle cycles afterwards
    repeat (3) @(posedge clk48);
    #1;
    check_all("reset", -1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    run_press("idle", '{low: 0, run: 100, rise: NONE, fall: 0, sp: NONE, lp: NONE});

    // Bounce: 2-cycle lows/highs never reach the debounce count
    for (int e = 0; e < 50; e++) begin
      usr_btn = (e < 30 && ((e / 2) % 2 == 0)) ? 1'b0 : 1'b1;
      @(posedge clk48);
      #1;
      check_all("bounce", e, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      run_press($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset on the second low cycle of reboot_n
    run_press("prerst", '{low: 100, run: 28, rise: 5, fall: NONE, sp: NONE, lp: 26});
    rst_n = 1'b0;
    #1;
    check_all("midrst", 27, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk48);
    #1;
    rst_n = 1'b1;
    run_press("repress", '{low: 100, run: 35, rise: 5, fall: NONE, sp: NONE, lp: 26});
    run_press("release", '{low: 0, run: 20, rise: -1, fall: 5, sp: NONE, lp: NONE});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
